// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//
// Shared definitions for the 32x32 register file and its command controller.
//   RF_DATA_W / RF_SEL_W : default register width and register-select width,
//                          shared with the `register` block.
//   op_e                 : command opcode encodings on cmd_op.
//   state_e              : controller FSM states.
//   isRejected()         : decides at accept time whether a command is
//                          answered with an error and no register-file access.
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_SEL_W  = 5;

    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_RD  = 2'b01,
        OP_CPY = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Register 0 is the hard-wired zero register, so any command that would
    // write it is refused, as is the unused opcode.
    function automatic logic isRejected(input logic [1:0] op, input logic dstIsZero);
        return (op == OP_ILL) || (((op == OP_WR) || (op == OP_CPY)) && dstIsZero);
    endfunction

endpackage

// File: rtl/regfile_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_cmd_ctrl
//
// Single master for the 32x32 register file. Accepts one WR / RD / CPY
// command at a time over a valid/ready command port, sequences the register
// file control pins, and returns exactly one response per command over a
// valid/ready response port.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   cmd_valid / cmd_ready         command handshake
//   cmd_op, cmd_dst, cmd_srcA,
//   cmd_srcB, cmd_data            command fields (sampled on accept only)
//   rsp_valid / rsp_ready         response handshake
//   rsp_a, rsp_b, rsp_err         response payload (stable while rsp_valid)
//   rf_EN, rf_write, rf_read      register-file strobes (single-cycle pulses)
//   rf_selectW1/R1/R2, rf_addr    register-file selects and write data
//   rf_outA, rf_outB              register-file read data (RD_LAT after read)
//   busy                          FSM is not idle
//
// Parameters: DATA_W, SEL_W, RD_LAT (1..3, read-data latency of the file).
// ----------------------------------------------------------------------------
module regfile_cmd_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int SEL_W  = RF_SEL_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_dst,
    input  logic [SEL_W-1:0]  cmd_srcA,
    input  logic [SEL_W-1:0]  cmd_srcB,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              rsp_err,
    output logic              rf_EN,
    output logic              rf_write,
    output logic              rf_read,
    output logic [SEL_W-1:0]  rf_selectW1,
    output logic [SEL_W-1:0]  rf_selectR1,
    output logic [SEL_W-1:0]  rf_selectR2,
    output logic [DATA_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_outA,
    input  logic [DATA_W-1:0] rf_outB,
    output logic              busy
);

    state_e            r_state;
    state_e            w_nextState;
    op_e               r_op;
    logic [SEL_W-1:0]  r_dst;
    logic [1:0]        r_waitCnt;
    logic [DATA_W-1:0] r_rspA;
    logic [DATA_W-1:0] r_rspB;
    logic              r_rspErr;
    logic              r_rfEN;
    logic              r_rfWrite;
    logic              r_rfRead;
    logic [SEL_W-1:0]  r_selW1;
    logic [SEL_W-1:0]  r_selR1;
    logic [SEL_W-1:0]  r_selR2;
    logic [DATA_W-1:0] r_rfAddr;

    logic              w_accept;
    logic              w_reject;
    logic              w_waitDone;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    assign w_reject   = isRejected(cmd_op, cmd_dst == '0);
    // The WAIT state lasts RD_LAT cycles; read data is taken on its last edge.
    assign w_waitDone = (r_waitCnt == 2'(RD_LAT - 1));

    assign cmd_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_a       = r_rspA;
    assign rsp_b       = r_rspB;
    assign rsp_err     = r_rspErr;
    assign rf_EN       = r_rfEN;
    assign rf_write    = r_rfWrite;
    assign rf_read     = r_rfRead;
    assign rf_selectW1 = r_selW1;
    assign rf_selectR1 = r_selR1;
    assign rf_selectR2 = r_selR2;
    assign rf_addr     = r_rfAddr;

    // State register. Reset drops any in-flight command back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Rejected commands skip the register file entirely
    // and go straight to the response.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_reject) begin
                        w_nextState = ST_RESP;
                    end else if (cmd_op == OP_WR) begin
                        w_nextState = ST_WRITE;
                    end else begin
                        w_nextState = ST_READ;
                    end
                end
            end
            ST_WRITE: w_nextState = ST_RESP;
            ST_READ:  w_nextState = ST_WAIT;
            ST_WAIT: begin
                if (w_waitDone) begin
                    w_nextState = (r_op == OP_CPY) ? ST_WRITE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Datapath and register-file drive. Strobes are registered and raised on
    // the edge that enters WRITE/READ, so they are high for exactly that state
    // cycle; selects and write data simply hold between accesses. For CPY the
    // write data is taken straight from rf_outA on the same edge that
    // captures it into rsp_a, so both carry the identical copied value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= OP_WR;
            r_dst     <= '0;
            r_waitCnt <= '0;
            r_rspA    <= '0;
            r_rspB    <= '0;
            r_rspErr  <= 1'b0;
            r_rfEN    <= 1'b0;
            r_rfWrite <= 1'b0;
            r_rfRead  <= 1'b0;
            r_selW1   <= '0;
            r_selR1   <= '0;
            r_selR2   <= '0;
            r_rfAddr  <= '0;
        end else begin
            r_rfEN    <= 1'b0;
            r_rfWrite <= 1'b0;
            r_rfRead  <= 1'b0;

            if (w_accept) begin
                r_op     <= op_e'(cmd_op);
                r_dst    <= cmd_dst;
                r_rspErr <= w_reject;
                r_rspB   <= '0;
                r_rspA   <= (!w_reject && (cmd_op == OP_WR)) ? cmd_data : '0;
                if (!w_reject) begin
                    if (cmd_op == OP_WR) begin
                        r_rfEN    <= 1'b1;
                        r_rfWrite <= 1'b1;
                        r_selW1   <= cmd_dst;
                        r_rfAddr  <= cmd_data;
                    end else begin
                        r_rfEN   <= 1'b1;
                        r_rfRead <= 1'b1;
                        r_selR1  <= cmd_srcA;
                        r_selR2  <= (cmd_op == OP_CPY) ? cmd_srcA : cmd_srcB;
                    end
                end
            end

            if (r_state == ST_READ) begin
                r_waitCnt <= '0;
            end

            if (r_state == ST_WAIT) begin
                r_waitCnt <= r_waitCnt + 2'd1;
                if (w_waitDone) begin
                    r_rspA <= rf_outA;
                    r_rspB <= (r_op == OP_CPY) ? '0 : rf_outB;
                    if (r_op == OP_CPY) begin
                        r_rfEN    <= 1'b1;
                        r_rfWrite <= 1'b1;
                        r_selW1   <= r_dst;
                        r_rfAddr  <= rf_outA;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_cmd_ctrl
//
// Self-checking bench for regfile_cmd_ctrl with RD_LAT=1. A behavioural
// register file is attached to the rf_* pins; expected responses come from a
// plain array model of register contents updated by command semantics.
// ----------------------------------------------------------------------------
module tb_regfile_cmd_ctrl;

    localparam logic [1:0] C_WR  = 2'b00;
    localparam logic [1:0] C_RD  = 2'b01;
    localparam logic [1:0] C_CPY = 2'b10;
    localparam logic [1:0] C_ILL = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_dst = '0;
    logic [4:0]  cmd_srcA = '0;
    logic [4:0]  cmd_srcB = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_a;
    logic [31:0] rsp_b;
    logic        rsp_err;
    logic        rf_EN;
    logic        rf_write;
    logic        rf_read;
    logic [4:0]  rf_selectW1;
    logic [4:0]  rf_selectR1;
    logic [4:0]  rf_selectR2;
    logic [31:0] rf_addr;
    logic [31:0] rf_outA = '0;
    logic [31:0] rf_outB = '0;
    logic        busy;

    int nTotal = 0;
    int nBad   = 0;

    logic [31:0] rfMem  [32] = '{default: 32'd0};
    logic [31:0] refMem [32] = '{default: 32'd0};
    int          writeCount = 0;
    int          readCount  = 0;
    logic [4:0]  lastWSel   = '0;
    logic [31:0] lastWData  = '0;

    regfile_cmd_ctrl #(.DATA_W(32), .SEL_W(5), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a),
        .rsp_b(rsp_b), .rsp_err(rsp_err),
        .rf_EN(rf_EN), .rf_write(rf_write), .rf_read(rf_read),
        .rf_selectW1(rf_selectW1), .rf_selectR1(rf_selectR1),
        .rf_selectR2(rf_selectR2), .rf_addr(rf_addr),
        .rf_outA(rf_outA), .rf_outB(rf_outB), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural register file (register 0 reads as zero) plus strobe
    // counters used to check pulse counts per command.
    always @(posedge clk) begin
        if (rf_EN && rf_write) begin
            writeCount <= writeCount + 1;
            lastWSel   <= rf_selectW1;
            lastWData  <= rf_addr;
            if (rf_selectW1 != 5'd0) rfMem[rf_selectW1] <= rf_addr;
        end
        if (rf_EN && rf_read) begin
            readCount <= readCount + 1;
            rf_outA   <= rfMem[rf_selectR1];
            rf_outB   <= rfMem[rf_selectR2];
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one command with rsp_ready high and reports what was observed:
    // cycles from accept to first rsp_valid (99 on timeout), the response
    // payload, and the number of write/read strobes seen meanwhile.
    task automatic issueCmd(input logic [1:0] op, input logic [4:0] dst,
                            input logic [4:0] sa, input logic [4:0] sb,
                            input logic [31:0] data, output int lat,
                            output logic [31:0] ra, output logic [31:0] rb,
                            output logic err, output int nW, output int nR);
        int w0;
        int r0;
        @(negedge clk);
        w0 = writeCount;
        r0 = readCount;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
        cmd_srcA = sa; cmd_srcB = sb; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_dst = 5'($urandom); cmd_srcA = 5'($urandom);
        cmd_srcB = 5'($urandom); cmd_data = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = 99;
        ra = rsp_a; rb = rsp_b; err = rsp_err;
        nW = writeCount - w0;
        nR = readCount - r0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        nTotal++;
        if (cmd_ready !== 1'b1) begin nBad++; $display("[TB] FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        nTotal++;
        if ({rsp_valid, busy, rf_EN, rf_write, rf_read, rsp_err, rf_selectW1, rf_selectR1, rf_selectR2} !== '0) begin
            nBad++; $display("[TB] FAIL reset_ctrl_outputs got nonzero want 0");
        end
        nTotal++;
        if ((rsp_a | rsp_b | rf_addr) !== 32'd0) begin nBad++; $display("[TB] FAIL reset_data_outputs got %h want 0", rsp_a | rsp_b | rf_addr); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int lat; int nW; int nR; logic [31:0] ra; logic [31:0] rb; logic err;
        issueCmd(C_WR, 5'd1, 5'd0, 5'd0, 32'd123, lat, ra, rb, err, nW, nR);
        refMem[1] = 32'd123;
        nTotal++; if (lat !== 2) begin nBad++; $display("[TB] FAIL wr_latency got %0d want 2", lat); end
        nTotal++; if ({ra, rb, err} !== {32'd123, 32'd0, 1'b0}) begin nBad++; $display("[TB] FAIL wr_rsp got a=%0d b=%0d err=%b want 123/0/0", ra, rb, err); end
        nTotal++; if (nW !== 1 || nR !== 0) begin nBad++; $display("[TB] FAIL wr_pulses got w=%0d r=%0d want 1/0", nW, nR); end
        nTotal++; if (lastWSel !== 5'd1 || lastWData !== 32'd123) begin nBad++; $display("[TB] FAIL wr_target got sel=%0d data=%0d want 1/123", lastWSel, lastWData); end
        nTotal++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin nBad++; $display("[TB] FAIL wr_idle_again got ready=%b busy=%b want 1/0", cmd_ready, busy); end
    endtask

    task automatic test_read();
        int lat; int nW; int nR; logic [31:0] ra; logic [31:0] rb; logic err;
        issueCmd(C_RD, 5'd0, 5'd1, 5'd2, 32'd0, lat, ra, rb, err, nW, nR);
        nTotal++; if (lat !== 3) begin nBad++; $display("[TB] FAIL rd_latency got %0d want 3", lat); end
        nTotal++; if ({ra, rb, err} !== {refMem[1], refMem[2], 1'b0}) begin nBad++; $display("[TB] FAIL rd_rsp got a=%0d b=%0d err=%b want %0d/%0d/0", ra, rb, err, refMem[1], refMem[2]); end
        nTotal++; if (nW !== 0 || nR !== 1) begin nBad++; $display("[TB] FAIL rd_pulses got w=%0d r=%0d want 0/1", nW, nR); end
    endtask

    task automatic test_copy();
        int lat; int nW; int nR; logic [31:0] ra; logic [31:0] rb; logic err;
        issueCmd(C_CPY, 5'd3, 5'd1, 5'd9, 32'd0, lat, ra, rb, err, nW, nR);
        refMem[3] = refMem[1];
        nTotal++; if (lat !== 4) begin nBad++; $display("[TB] FAIL cpy_latency got %0d want 4", lat); end
        nTotal++; if ({ra, rb, err} !== {32'd123, 32'd0, 1'b0}) begin nBad++; $display("[TB] FAIL cpy_rsp got a=%0d b=%0d err=%b want 123/0/0", ra, rb, err); end
        nTotal++; if (nW !== 1 || nR !== 1) begin nBad++; $display("[TB] FAIL cpy_pulses got w=%0d r=%0d want 1/1", nW, nR); end
        nTotal++; if (lastWSel !== 5'd3 || lastWData !== 32'd123) begin nBad++; $display("[TB] FAIL cpy_target got sel=%0d data=%0d want 3/123", lastWSel, lastWData); end
        issueCmd(C_RD, 5'd0, 5'd3, 5'd1, 32'd0, lat, ra, rb, err, nW, nR);
        nTotal++; if ({ra, rb} !== {32'd123, 32'd123}) begin nBad++; $display("[TB] FAIL cpy_readback got %0d/%0d want 123/123", ra, rb); end
    endtask

    task automatic test_errors();
        int lat; int nW; int nR; logic [31:0] ra; logic [31:0] rb; logic err;
        issueCmd(C_WR, 5'd0, 5'd0, 5'd0, 32'd456, lat, ra, rb, err, nW, nR);
        nTotal++; if (lat !== 1 || err !== 1'b1) begin nBad++; $display("[TB] FAIL err_wr0 got lat=%0d err=%b want 1/1", lat, err); end
        nTotal++; if ({ra, rb} !== 64'd0 || nW !== 0 || nR !== 0) begin nBad++; $display("[TB] FAIL err_wr0_side got a=%0d b=%0d w=%0d r=%0d want 0/0/0/0", ra, rb, nW, nR); end
        issueCmd(C_ILL, 5'd4, 5'd1, 5'd1, 32'd77, lat, ra, rb, err, nW, nR);
        nTotal++; if (lat !== 1 || err !== 1'b1) begin nBad++; $display("[TB] FAIL err_op11 got lat=%0d err=%b want 1/1", lat, err); end
        nTotal++; if ({ra, rb} !== 64'd0 || nW !== 0 || nR !== 0) begin nBad++; $display("[TB] FAIL err_op11_side got a=%0d b=%0d w=%0d r=%0d want 0/0/0/0", ra, rb, nW, nR); end
        issueCmd(C_CPY, 5'd0, 5'd1, 5'd1, 32'd0, lat, ra, rb, err, nW, nR);
        nTotal++; if (lat !== 1 || err !== 1'b1 || nW !== 0 || nR !== 0) begin nBad++; $display("[TB] FAIL err_cpy0 got lat=%0d err=%b w=%0d r=%0d want 1/1/0/0", lat, err, nW, nR); end
        issueCmd(C_RD, 5'd0, 5'd0, 5'd1, 32'd0, lat, ra, rb, err, nW, nR);
        nTotal++; if ({ra, rb, err} !== {32'd0, refMem[1], 1'b0}) begin nBad++; $display("[TB] FAIL rd_reg0 got a=%0d b=%0d err=%b want 0/%0d/0", ra, rb, err, refMem[1]); end
    endtask

    task automatic test_backpressure();
        int waitCyc;
        logic stableOk;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = C_RD; cmd_srcA = 5'd3; cmd_srcB = 5'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        waitCyc = 1;
        while (!rsp_valid && waitCyc < 20) begin @(negedge clk); waitCyc++; end
        nTotal++; if (!rsp_valid) begin nBad++; $display("[TB] FAIL bp_response got timeout want rsp_valid"); end
        stableOk = 1'b1;
        repeat (5) begin
            cmd_valid = 1'b1; cmd_op = C_WR; cmd_dst = 5'd5; cmd_data = $urandom;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_a !== refMem[3] || rsp_b !== refMem[1] || rsp_err !== 1'b0)
                stableOk = 1'b0;
        end
        cmd_valid = 1'b0;
        nTotal++; if (stableOk !== 1'b1) begin nBad++; $display("[TB] FAIL bp_stable got unstable response want held stable"); end
        rsp_ready = 1'b1;
        @(negedge clk);
        nTotal++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin nBad++; $display("[TB] FAIL bp_release got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
        nTotal++; if (refMem[5] !== rfMem[5]) begin nBad++; $display("[TB] FAIL bp_ignored_cmd got reg5=%0d want %0d", rfMem[5], refMem[5]); end
    endtask

    task automatic test_reset_mid();
        int w0; int lat; int nW; int nR; logic [31:0] ra; logic [31:0] rb; logic err;
        logic sawValid;
        @(negedge clk);
        w0 = writeCount;
        cmd_valid = 1'b1; cmd_op = C_CPY; cmd_dst = 5'd7; cmd_srcA = 5'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        nTotal++;
        if ({rsp_valid, busy, rf_EN, rf_write, rf_read, rsp_err, rf_selectW1, rf_selectR1, rf_selectR2} !== '0 ||
            (rsp_a | rsp_b | rf_addr) !== 32'd0 || cmd_ready !== 1'b1) begin
            nBad++; $display("[TB] FAIL midreset_outputs got busy=%b ready=%b rsp_a=%0d want 0/1/0", busy, cmd_ready, rsp_a);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sawValid = 1'b0;
        repeat (6) begin @(negedge clk); if (rsp_valid) sawValid = 1'b1; end
        nTotal++; if (sawValid !== 1'b0 || writeCount !== w0) begin nBad++; $display("[TB] FAIL midreset_no_write got valid=%b writes=%0d want 0/0", sawValid, writeCount - w0); end
        issueCmd(C_RD, 5'd0, 5'd7, 5'd0, 32'd0, lat, ra, rb, err, nW, nR);
        nTotal++; if (ra !== refMem[7]) begin nBad++; $display("[TB] FAIL midreset_reg7 got %0d want %0d", ra, refMem[7]); end
    endtask

    task automatic test_random();
        int lat; int nW; int nR; logic [31:0] ra; logic [31:0] rb; logic err;
        int expLat; int expW; int expR; logic [31:0] expA; logic [31:0] expB; logic expErr;
        logic [1:0] op; logic [4:0] dst; logic [4:0] sa; logic [4:0] sb; logic [31:0] data;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            sa = 5'($urandom); sb = 5'($urandom); data = $urandom;
            expErr = (op == C_ILL) || ((op != C_RD) && (dst == 5'd0));
            if (expErr) begin
                expLat = 1; expA = 0; expB = 0; expW = 0; expR = 0;
            end else if (op == C_WR) begin
                expLat = 2; expA = data; expB = 0; expW = 1; expR = 0;
            end else if (op == C_RD) begin
                expLat = 3; expA = refMem[sa]; expB = refMem[sb]; expW = 0; expR = 1;
            end else begin
                expLat = 4; expA = refMem[sa]; expB = 0; expW = 1; expR = 1;
            end
            issueCmd(op, dst, sa, sb, data, lat, ra, rb, err, nW, nR);
            if (!expErr && op != C_RD) refMem[dst] = expA;
            nTotal++;
            if (lat !== expLat || ra !== expA || rb !== expB || err !== expErr || nW !== expW || nR !== expR) begin
                nBad++;
                $display("[TB] FAIL rand_%0d op=%0d got lat=%0d a=%h b=%h err=%b w=%0d r=%0d want lat=%0d a=%h b=%h err=%b w=%0d r=%0d",
                         i, op, lat, ra, rb, err, nW, nR, expLat, expA, expB, expErr, expW, expR);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_copy();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
